// File: rtl/seq_detect_param.sv
// Serial pattern detector with a run-time loadable pattern, a per-bit
// don't-care mask, overlapping and non-overlapping match modes, and a
// saturating match counter. Every output comes straight from a register.
module seq_detect_param #(
  parameter int             W           = 8,
  parameter int             CNT_W       = 8,
  parameter logic [W-1:0]   RST_PATTERN = W'('b10011010)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_vld,
  input  logic             in,
  input  logic             cfg_vld,
  input  logic [W-1:0]     cfg_pattern,
  input  logic [W-1:0]     cfg_mask,
  input  logic             cfg_overlap,
  input  logic             cnt_clr,
  output logic             match,
  output logic [CNT_W-1:0] match_cnt,
  output logic             hist_full
);

  localparam int                HIST_W   = $clog2(W + 1);
  localparam logic [HIST_W-1:0] HIST_MAX = HIST_W'(W);

  logic [W-1:0]      shift_r;
  logic [W-1:0]      pattern_r;
  logic [W-1:0]      mask_r;
  logic              overlap_r;
  logic [HIST_W-1:0] hist;

  logic [W-1:0]      shift_w;
  logic [HIST_W-1:0] hist_w;
  logic              hit_p0;

  // History depth only needs to know "at least W bits seen", so it parks at W.
  function automatic logic [HIST_W-1:0] hist_sat_inc(input logic [HIST_W-1:0] v);
    return (v == HIST_MAX) ? v : v + 1'b1;
  endfunction

  // Match counter sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] cnt_sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  // Stage p0: post-shift window and masked compare for the current beat.
  // A config load in the same cycle swallows the beat, so it cannot match.
  always_comb begin
    shift_w = (shift_r << 1) | W'(in);
    hist_w  = hist_sat_inc(hist);
    hit_p0  = in_vld && !cfg_vld && (hist_w == HIST_MAX) &&
              (((shift_w ^ pattern_r) & mask_r) == '0);
  end

  // Stage p1: window, history depth, configuration and the match pulse.
  // Non-overlapping mode restarts the history after a hit so the next
  // occurrence has to be built from W fresh bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      shift_r   <= '0;
      hist      <= '0;
      pattern_r <= RST_PATTERN;
      mask_r    <= '1;
      overlap_r <= 1'b1;
      match     <= 1'b0;
    end else begin
      match <= hit_p0;
      if (cfg_vld) begin
        pattern_r <= cfg_pattern;
        mask_r    <= cfg_mask;
        overlap_r <= cfg_overlap;
        shift_r   <= '0;
        hist      <= '0;
      end else if (in_vld) begin
        shift_r <= shift_w;
        hist    <= (hit_p0 && !overlap_r) ? '0 : hist_w;
      end
    end
  end

  // Stage p2: count registered match pulses; a clear in the same cycle as a
  // pulse clears first and then counts that pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      match_cnt <= '0;
    end else if (cnt_clr) begin
      match_cnt <= match ? CNT_W'(1) : '0;
    end else if (match) begin
      match_cnt <= cnt_sat_inc(match_cnt);
    end
  end

  assign hist_full = (hist == HIST_MAX);

endmodule

// File: tb/tb_seq_detect_param.sv
// Directed bench for seq_detect_param: the driver queues the cycle in which
// each match pulse is due, and an independent monitor pops and compares
// whenever the DUT raises match.
module tb_seq_detect_param;

  localparam int W     = 8;
  localparam int CNT_W = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_vld;
  logic             in;
  logic             cfg_vld;
  logic [W-1:0]     cfg_pattern;
  logic [W-1:0]     cfg_mask;
  logic             cfg_overlap;
  logic             cnt_clr;
  logic             match;
  logic [CNT_W-1:0] match_cnt;
  logic             hist_full;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int exp_q[$];

  seq_detect_param #(.W(W), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_vld      (in_vld),
    .in          (in),
    .cfg_vld     (cfg_vld),
    .cfg_pattern (cfg_pattern),
    .cfg_mask    (cfg_mask),
    .cfg_overlap (cfg_overlap),
    .cnt_clr     (cnt_clr),
    .match       (match),
    .match_cnt   (match_cnt),
    .hist_full   (hist_full)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every match pulse must correspond to the oldest queued expectation.
  always @(negedge clk) begin
    if (cyc > 0 && match !== 1'b0) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL spurious_match: cycle %0d match=%b, required no match", cyc, match);
      end else begin
        int e;
        e = exp_q.pop_front();
        if (e != cyc || match !== 1'b1) begin
          errors++;
          $display("FAIL match_cycle: match=%b at cycle %0d, required pulse at cycle %0d",
                   match, cyc, e);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // One cycle of stimulus, applied at the falling edge; a beat expected to
  // match is captured at the next rising edge and pulses match right after it.
  task automatic step(input logic v, input logic b, input logic c,
                      input logic clr, input logic expm);
    @(negedge clk);
    in_vld  = v;
    in      = b;
    cfg_vld = c;
    cnt_clr = clr;
    if (expm) exp_q.push_back(cyc + 1);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Send n beats MSB first; expm bit (n-k) flags beat k (1-based) as a match.
  task automatic send(input logic [31:0] bits, input int n, input logic [31:0] expm);
    for (int i = n - 1; i >= 0; i--) step(1'b1, bits[i], 1'b0, 1'b0, expm[i]);
  endtask

  task automatic cfg(input logic [W-1:0] pat, input logic [W-1:0] msk, input logic ov);
    @(negedge clk);
    cfg_pattern = pat;
    cfg_mask    = msk;
    cfg_overlap = ov;
    in_vld      = 1'b0;
    in          = 1'b0;
    cfg_vld     = 1'b1;
    cnt_clr     = 1'b0;
  endtask

  task automatic clear_cnt();
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; in_vld = 1'b0; in = 1'b0; cfg_vld = 1'b0; cnt_clr = 1'b0;
    cfg_pattern = '0; cfg_mask = '0; cfg_overlap = 1'b0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_match", 32'(match), 32'd0);
    chk("rst_cnt", 32'(match_cnt), 32'd0);
    chk("rst_hist_full", 32'(hist_full), 32'd0);
    rst = 1'b0;

    // Reset pattern detected, pulse one cycle after the 8th beat
    send(32'b10011010, 8, 32'h1);
    idle(3);
    chk("a_cnt", 32'(match_cnt), 32'd1);
    chk("a_hist_full", 32'(hist_full), 32'd1);
    clear_cnt();

    // Overlapping: 14-beat stream matches after beats 8 and 14
    cfg(8'b10011010, 8'hFF, 1'b1);
    send(32'b10011010011010, 14, 32'h41);
    idle(3);
    chk("b_overlap_cnt", 32'(match_cnt), 32'd2);
    clear_cnt();

    // Non-overlapping: same stream matches only after beat 8, history restarts
    cfg(8'b10011010, 8'hFF, 1'b0);
    send(32'b10011010011010, 14, 32'h40);
    idle(3);
    chk("c_nonoverlap_cnt", 32'(match_cnt), 32'd1);
    chk("c_hist_full", 32'(hist_full), 32'd0);
    clear_cnt();

    // Gap of 3 invalid cycles between beats 4 and 5
    cfg(8'b10011010, 8'hFF, 1'b1);
    send(32'b1001, 4, 32'h0);
    idle(3);
    send(32'b1010, 4, 32'h1);
    idle(3);
    chk("d_gap_cnt", 32'(match_cnt), 32'd1);
    clear_cnt();

    // Masked compare: low nibble is don't-care
    cfg(8'b10010000, 8'hF0, 1'b1);
    send(32'b10010111, 8, 32'h1);
    idle(3);
    chk("e_mask_cnt", 32'(match_cnt), 32'd1);
    // Config load coincident with a beat: beat dropped, history cleared
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    idle(1);
    chk("e_cfg_drop_hist", 32'(hist_full), 32'd0);
    send(32'b1001000, 7, 32'h0);
    idle(1);
    chk("e_seven_beats_hist", 32'(hist_full), 32'd0);
    send(32'b0, 1, 32'h1);
    idle(3);
    chk("e_mask_cnt2", 32'(match_cnt), 32'd2);
    chk("e_hist_full", 32'(hist_full), 32'd1);
    clear_cnt();

    // All-zero mask, overlapping: beats 8..12 all match, counter saturates at 3
    cfg(8'h00, 8'h00, 1'b1);
    send(32'h0, 12, 32'h1F);
    idle(3);
    chk("f_sat_cnt", 32'(match_cnt), 32'd3);
    // 6th match with a clear coincident with its pulse -> 1
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(2);
    chk("f_clr_and_count", 32'(match_cnt), 32'd1);

    // All-zero mask, non-overlapping: a match every 8 beats
    cfg(8'h00, 8'h00, 1'b0);
    send(32'h0, 16, 32'h101);
    idle(3);
    chk("f_nonoverlap_cnt", 32'(match_cnt), 32'd3);

    // Reset mid-pattern discards history and restores the reset pattern
    cfg(8'hAA, 8'hFF, 1'b1);
    send(32'b1001101, 7, 32'h0);
    @(negedge clk);
    in_vld = 1'b0; cfg_vld = 1'b0; cnt_clr = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    send(32'b0, 1, 32'h0);
    idle(3);
    chk("g_rst_cnt", 32'(match_cnt), 32'd0);
    chk("g_rst_hist_full", 32'(hist_full), 32'd0);
    send(32'b10011010, 8, 32'h1);
    idle(3);
    chk("g_rst_pattern_cnt", 32'(match_cnt), 32'd1);

    idle(5);
    chk("missing_matches", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_detect_param.md
SEQ_DETECT_PARAM -- requirements
Module: seq_detect_param

Interface
REQ-001 The parameter W SHALL default to 8 and set the pattern length in bits; the legal range is 2..32.
REQ-002 The parameter CNT_W SHALL default to 8 and set the width of the match counter.
REQ-003 The parameter RST_PATTERN SHALL default to 'b10011010 (W bits) and set the pattern loaded at reset.
REQ-004 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 rst  input  1  SHALL be the synchronous, active-high reset.
REQ-006 in_vld  input  1  SHALL qualify the serial data bit `in`.
REQ-007 in  input  1  SHALL be the serial data bit, sampled only when in_vld=1.
REQ-008 cfg_vld  input  1  SHALL be a single-cycle configuration load strobe.
REQ-009 cfg_pattern  input  W  SHALL be the new pattern; bit W-1 is the first bit received.
REQ-010 cfg_mask  input  W  SHALL be the per-bit compare enable; 0 = don't-care.
REQ-011 cfg_overlap  input  1  SHALL select the match mode: 1 = overlapping, 0 = non-overlapping.
REQ-012 cnt_clr  input  1  SHALL be the match-counter clear strobe.
REQ-013 match  output  1  SHALL be a one-cycle registered pulse per detected occurrence.
REQ-014 match_cnt  output  CNT_W  SHALL be the saturating count of matches.
REQ-015 hist_full  output  1  SHALL be 1 when at least W valid bits have been captured since the last history clear.

Function
REQ-016 Shift register: on in_vld=1, shift_r SHALL become {shift_r[W-2:0], in}; the newest bit is at the LSB. On in_vld=0, shift_r SHALL hold.
REQ-017 History counter hist (range 0..W) SHALL increment on each in_vld beat and saturate at W; hist_full = (hist == W).
REQ-018 Match condition per in_vld beat, evaluated on the post-shift value: the beat SHALL match when hist_next == W and ((shift_w ^ pattern_r) & mask_r) == 0.
REQ-019 match SHALL assert in the cycle after the completing in_vld beat (1-cycle latency) and SHALL be 0 in all other cycles.
REQ-020 Overlapping mode: hist SHALL be unaffected by a match, so a trailing suffix of one match may begin the next.
REQ-021 Non-overlapping mode: a matching beat SHALL set hist to 0, so the next match needs W fresh beats.
REQ-022 An all-zero mask SHALL match on every in_vld beat once hist_full (overlap) or every W beats (non-overlap).
REQ-023 On cfg_vld=1, pattern_r, mask_r and overlap_r SHALL load from the cfg inputs, hist and shift_r SHALL clear to 0, and match_cnt SHALL be unchanged.
REQ-024 If cfg_vld and in_vld are high in the same cycle, cfg_vld SHALL win: the data bit is discarded and no match is generated.
REQ-025 match_cnt SHALL increment by 1 on each match pulse and saturate at 2^CNT_W-1; it SHALL not wrap.
REQ-026 If cnt_clr and a match increment coincide, match_cnt SHALL become 1 (clear, then count).
REQ-027 No combinational path SHALL exist from any input to any output.

Reset
REQ-028 While rst=1, shift_r and hist SHALL be 0, match=0, match_cnt=0, pattern_r=RST_PATTERN, mask_r=all-ones and overlap_r=1.
REQ-029 rst SHALL take priority over cfg_vld, in_vld and cnt_clr; asserting it mid-pattern SHALL discard the partial history.

Verification
REQ-030 Reset, then apply 8 beats 1,0,0,1,1,0,1,0 -> match=1 exactly one cycle after the 8th beat, then match_cnt=1.
REQ-031 Overlap mode: stream 10011010 followed by 011010 (14 contiguous beats) -> matches after beats 8 and 14, then match_cnt=2. The same stream with cfg_overlap=0 -> a single match after beat 8.
REQ-032 The same 8-bit stream with in_vld deasserted for 3 cycles between beats 4 and 5 -> a single match, one cycle after beat 8.
REQ-033 Load cfg_mask=8'b11110000 with cfg_pattern=8'b1001xxxx, send 1001_0111 -> match; cfg_vld coincident with a beat -> the beat is dropped and hist_full=0.
REQ-034 With CNT_W=2, produce 5 matches -> match_cnt sticks at 3; cnt_clr coincident with the 6th match -> match_cnt=1.
REQ-035 Assert rst after 7 of the 8 pattern beats, then send the final bit 0 -> no match; match_cnt=0 and pattern_r=RST_PATTERN.
